// File: rtl/dma_wtp_ctl_pkg.sv
// Shared types for the DMA wait-port controller: FSM states and transfer direction.
package dma_wtp_ctl_pkg;

    localparam int unsigned DEV_W  = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_REQ,
        ST_WAIT,
        ST_PUSH,
        ST_NEXT,
        ST_END
    } wtp_state_e;

    // Writes need a byte from the DMA engine before the wait can be raised.
    function automatic wtp_state_e byte_entry_state(input logic dir);
        return (dir == DIR_WR) ? ST_FETCH : ST_REQ;
    endfunction

endpackage

// File: rtl/dma_wtp_ctl_if.sv
// Bus bundle for dma_wtp_ctl: DMA-engine side, zwait side and status.
interface dma_wtp_ctl_if;
    import dma_wtp_ctl_pkg::*;

    logic              start;
    logic              dir;
    logic [DEV_W-1:0]  dev;
    logic [CNT_W-1:0]  len;
    logic              abort;
    logic [BYTE_W-1:0] wr_data;
    logic              wr_vld;
    logic              wr_rdy;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_vld;
    logic              rd_rdy;
    logic              dma_wtp_req;
    logic              dma_wtp_stb;
    logic [DEV_W-1:0]  dmawpdev;
    logic [BYTE_W-1:0] wtp_dout;
    logic [BYTE_W-1:0] wtp_din;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, dir, dev, len, abort, wr_data, wr_vld, rd_rdy,
               dma_wtp_stb, wtp_din,
        output wr_rdy, rd_data, rd_vld, dma_wtp_req, dmawpdev, wtp_dout,
               busy, done, err
    );

    modport slave (
        output start, dir, dev, len, abort, wr_data, wr_vld, rd_rdy,
               dma_wtp_stb, wtp_din,
        input  wr_rdy, rd_data, rd_vld, dma_wtp_req, dmawpdev, wtp_dout,
               busy, done, err
    );

endinterface

// File: rtl/dma_wtp_ctl_timeout.sv
// Per-byte wait timeout: counts from the req cycle, expires after 2**TO_W-1 cycles.
module wtp_timeout #(
    parameter int unsigned TO_W = 16
) (
    input  logic fclk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] ONE    = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] ALMOST = {{(TO_W-1){1'b1}}, 1'b0};

    logic [TO_W-1:0] cnt_q, cnt_d;

    // The req cycle counts as the first one, so the count turns all-ones on the
    // edge that leaves WAIT, 2**TO_W-1 cycles after req.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = ONE;
        end else if (en_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    assign expire_o = en_i && (cnt_q == ALMOST);

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dma_wtp_ctl.sv
// DMA-side wait-port controller: moves a burst one byte per zwait wait,
// with per-byte timeout, abort and sticky error.
module dma_wtp_ctl
    import dma_wtp_ctl_pkg::*;
#(
    parameter int unsigned TO_W = 16
) (
    input  logic          fclk,
    input  logic          rst_n,
    dma_wtp_ctl_if.master bus
);

    wtp_state_e        state_q, state_d;
    logic              dir_q, dir_d;
    logic [DEV_W-1:0]  dev_q, dev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic [BYTE_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic to_clr, to_en, to_expire;
    logic req, wr_rdy, rd_vld, done;

    wtp_timeout #(
        .TO_W (TO_W)
    ) u_timeout (
        .fclk     (fclk),
        .rst_n    (rst_n),
        .clr_i    (to_clr),
        .en_i     (to_en),
        .expire_o (to_expire)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dev_d   = dev_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_clr  = 1'b0;
        to_en   = 1'b0;
        req     = 1'b0;
        wr_rdy  = 1'b0;
        rd_vld  = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dir_d   = bus.dir;
                    dev_d   = bus.dev;
                    cnt_d   = bus.len;
                    err_d   = 1'b0;
                    state_d = byte_entry_state(bus.dir);
                end
            end
            ST_FETCH: begin
                wr_rdy = 1'b1;
                if (bus.wr_vld) begin
                    dout_d  = bus.wr_data;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req     = 1'b1;
                to_clr  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                to_en = 1'b1;
                if (bus.dma_wtp_stb) begin
                    if (dir_q == DIR_RD) begin
                        rdata_d = bus.wtp_din;
                    end
                    state_d = (dir_q == DIR_WR) ? ST_NEXT : ST_PUSH;
                end else if (to_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_END;
                end
            end
            ST_PUSH: begin
                rd_vld = 1'b1;
                if (bus.rd_rdy) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (cnt_q == '0) begin
                    state_d = ST_END;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = byte_entry_state(dir_q);
                end
            end
            ST_END: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything mid-burst: no handshake may complete and no
        // data or error state is updated; END itself always proceeds to IDLE.
        if (bus.abort && (state_q != ST_IDLE) && (state_q != ST_END)) begin
            state_d = ST_END;
            cnt_d   = cnt_q;
            dout_d  = dout_q;
            rdata_d = rdata_q;
            err_d   = err_q;
            req     = 1'b0;
            wr_rdy  = 1'b0;
            rd_vld  = 1'b0;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            dev_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dev_q   <= dev_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.dma_wtp_req = req;
    assign bus.wr_rdy      = wr_rdy;
    assign bus.rd_vld      = rd_vld;
    assign bus.done        = done;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.err         = err_q;
    assign bus.dmawpdev    = dev_q;
    assign bus.wtp_dout    = dout_q;
    assign bus.rd_data     = rdata_q;

endmodule

// File: tb/tb_dma_wtp_ctl.sv
// Directed self-checking bench for dma_wtp_ctl (TO_W=4 so timeouts are short).
module tb_dma_wtp_ctl;

    logic clk;
    logic rst_n;

    dma_wtp_ctl_if bus ();

    dma_wtp_ctl #(
        .TO_W (4)
    ) dut (
        .fclk  (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;

    int          nreq, nrd, nvld, ndone, done_cyc, busy_after;
    logic [7:0]  dout_log[$];
    logic [7:0]  rd_log[$];
    logic [1:0]  dev_log[$];
    int          req_cyc[$];
    logic [7:0]  wdata[$];

    task automatic pulse_start(input logic d, input logic [1:0] dv, input logic [7:0] ln);
        bus.start = 1'b1;
        bus.dir   = d;
        bus.dev   = dv;
        bus.len   = ln;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Environment driver for one burst: feeds wr_data, answers each req with a
    // stb after a delay (<0 = never), throttles rd_rdy, and logs what it sees.
    task automatic run_burst(input int first_delay, input int stb_delay, input int rd_hold,
                             input int restart_at, input int budget,
                             input logic [7:0] din_base, input int din_step);
        int timer;
        int vld_cnt;
        int widx;
        int tail;
        bit seen_done;
        nreq = 0; nrd = 0; nvld = 0; ndone = 0; done_cyc = -1; busy_after = 1;
        dout_log.delete(); rd_log.delete(); dev_log.delete(); req_cyc.delete();
        timer = 0; vld_cnt = 0; widx = 0; tail = 0; seen_done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (seen_done) begin
                tail++;
                if (tail == 1) busy_after = int'(bus.busy);
            end
            if (bus.done) begin
                ndone++;
                done_cyc  = c;
                seen_done = 1'b1;
            end
            if (timer > 0) begin
                timer--;
                bus.dma_wtp_stb = (timer == 0);
            end else begin
                bus.dma_wtp_stb = 1'b0;
            end
            if (bus.dma_wtp_req) begin
                dout_log.push_back(bus.wtp_dout);
                dev_log.push_back(bus.dmawpdev);
                req_cyc.push_back(c);
                timer = (nreq == 0) ? first_delay : stb_delay;
                bus.wtp_din = din_base + 8'(nreq * din_step);
                nreq++;
            end
            if (bus.rd_vld) begin
                nvld++;
                if (vld_cnt >= rd_hold) begin
                    bus.rd_rdy = 1'b1;
                    rd_log.push_back(bus.rd_data);
                    nrd++;
                    vld_cnt = 0;
                end else begin
                    bus.rd_rdy = 1'b0;
                    vld_cnt++;
                end
            end else begin
                bus.rd_rdy = 1'b0;
            end
            if (bus.wr_rdy) begin
                bus.wr_vld  = 1'b1;
                bus.wr_data = (widx < wdata.size()) ? wdata[widx] : 8'h00;
                widx++;
            end else begin
                bus.wr_vld = 1'b0;
            end
            if (c == restart_at) begin
                bus.start = 1'b1;
                bus.dir   = 1'b0;
                bus.dev   = 2'd3;
                bus.len   = 8'd7;
            end else begin
                bus.start = 1'b0;
            end
            if (tail >= 3) break;
            @(negedge clk);
        end
        if (!seen_done) $display("FAIL burst_budget: no done within %0d cycles (required done)", budget);
        bus.dma_wtp_stb = 1'b0;
        bus.wr_vld      = 1'b0;
        bus.rd_rdy      = 1'b0;
        bus.start       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.dir = 1'b0; bus.dev = '0; bus.len = '0; bus.abort = 1'b0;
        bus.wr_data = '0; bus.wr_vld = 1'b0; bus.rd_rdy = 1'b0;
        bus.dma_wtp_stb = 1'b0; bus.wtp_din = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.dma_wtp_req, bus.wr_rdy, bus.rd_vld} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {bus.busy, bus.done, bus.err, bus.dma_wtp_req, bus.wr_rdy, bus.rd_vld});
        end
        checks++;
        if ({bus.dmawpdev, bus.wtp_dout, bus.rd_data} !== 18'h0) begin
            errors++;
            $display("FAIL reset_data: dev=%0d dout=%h rd=%h required all 0",
                     bus.dmawpdev, bus.wtp_dout, bus.rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int bad;
        logic [7:0] got;
        wdata = '{8'h11, 8'h22, 8'h33};
        pulse_start(1'b1, 2'd1, 8'd2);
        run_burst(5, 5, 0, -1, 200, 8'h00, 0);
        checks++;
        if (nreq !== 3) begin errors++; $display("FAIL wr_req_count: got %0d required 3", nreq); end
        for (int i = 0; i < 3; i++) begin
            got = (i < dout_log.size()) ? dout_log[i] : 8'hxx;
            checks++;
            if (got !== wdata[i]) begin
                errors++;
                $display("FAIL wr_dout[%0d]: got %h required %h", i, got, wdata[i]);
            end
        end
        bad = 0;
        foreach (dev_log[i]) if (dev_log[i] !== 2'd1) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL wr_dev: %0d reqs with dmawpdev!=1", bad); end
        checks++;
        if (req_cyc.size() < 2 || req_cyc[1] - req_cyc[0] !== 8) begin
            errors++;
            $display("FAIL wr_req_gap: got %0d required 8",
                     (req_cyc.size() < 2) ? -1 : req_cyc[1] - req_cyc[0]);
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL wr_done: got %0d pulses required 1", ndone); end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b required 0", bus.err); end
        checks++;
        if (busy_after !== 0) begin errors++; $display("FAIL wr_busy_after: got %0d required 0", busy_after); end
    endtask

    task automatic test_read();
        pulse_start(1'b0, 2'd2, 8'd0);
        run_burst(3, 3, 4, -1, 100, 8'hA5, 0);
        checks++;
        if (nrd !== 1 || rd_log.size() < 1 || rd_log[0] !== 8'hA5) begin
            errors++;
            $display("FAIL rd_data: handshakes=%0d first=%h required 1 x a5", nrd,
                     (rd_log.size() > 0) ? rd_log[0] : 8'hxx);
        end
        checks++;
        if (nvld !== 5) begin errors++; $display("FAIL rd_vld_hold: got %0d cycles required 5", nvld); end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL rd_done: got %0d required 1", ndone); end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b required 0", bus.err); end
    endtask

    task automatic test_timeout();
        wdata = '{8'h5C};
        pulse_start(1'b1, 2'd0, 8'd0);
        run_burst(-1, -1, 0, -1, 100, 8'h00, 0);
        checks++;
        if (nreq !== 1) begin errors++; $display("FAIL to_req_count: got %0d required 1", nreq); end
        checks++;
        if (req_cyc.size() < 1 || done_cyc - req_cyc[0] !== 15) begin
            errors++;
            $display("FAIL to_latency: got %0d required 15",
                     (req_cyc.size() < 1) ? -1 : done_cyc - req_cyc[0]);
        end
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL to_err: got %b required 1", bus.err); end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL to_done: got %0d required 1", ndone); end
        checks++;
        if (busy_after !== 0) begin errors++; $display("FAIL to_busy_after: got %0d required 0", busy_after); end
    endtask

    task automatic test_start_while_busy();
        int bad;
        wdata = '{8'hA1, 8'hB2};
        pulse_start(1'b1, 2'd2, 8'd1);
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL busy_err_clear: got %b required 0", bus.err); end
        run_burst(2, 2, 0, 1, 100, 8'h00, 0);
        checks++;
        if (nreq !== 2 || dout_log.size() != 2 || dout_log[0] !== 8'hA1 || dout_log[1] !== 8'hB2) begin
            errors++;
            $display("FAIL busy_bytes: got %0d reqs required 2 (a1,b2)", nreq);
        end
        bad = 0;
        foreach (dev_log[i]) if (dev_log[i] !== 2'd2) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL busy_dev: %0d reqs with dmawpdev!=2", bad); end
        checks++;
        if (nrd !== 0) begin errors++; $display("FAIL busy_dir: got %0d reads required 0", nrd); end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL busy_done: got %0d required 1", ndone); end
    endtask

    task automatic test_long_read_race();
        int bad;
        pulse_start(1'b0, 2'd3, 8'd255);
        run_burst(14, 1, 0, -1, 3000, 8'h10, 3);
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL race_err: got %b required 0", bus.err); end
        checks++;
        if (nrd !== 256) begin errors++; $display("FAIL long_rd_count: got %0d required 256", nrd); end
        checks++;
        if (nreq !== 256) begin errors++; $display("FAIL long_req_count: got %0d required 256", nreq); end
        bad = 0;
        foreach (rd_log[i]) if (rd_log[i] !== 8'(8'h10 + i * 3)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL long_rd_data: %0d bytes wrong required 0", bad); end
        checks++;
        if (req_cyc.size() < 2 || req_cyc[255] - req_cyc[254] !== 4) begin
            errors++;
            $display("FAIL long_req_gap: got %0d required 4",
                     (req_cyc.size() < 256) ? -1 : req_cyc[255] - req_cyc[254]);
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL long_done: got %0d required 1", ndone); end
    endtask

    task automatic test_abort();
        logic [7:0] prev;
        pulse_start(1'b0, 2'd2, 8'd3);
        checks++;
        if (bus.dma_wtp_req !== 1'b1) begin errors++; $display("FAIL ab_req_seen: got %b required 1", bus.dma_wtp_req); end
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.dma_wtp_req !== 1'b0) begin
            errors++;
            $display("FAIL ab_end: done=%b req=%b required 1/0", bus.done, bus.dma_wtp_req);
        end
        bus.abort = 1'b0;
        bus.dma_wtp_stb = 1'b1;
        @(negedge clk);
        bus.dma_wtp_stb = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL ab_idle: busy=%b done=%b required 0/0", bus.busy, bus.done);
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.rd_vld, bus.done, bus.err} !== 4'b0) begin
            errors++;
            $display("FAIL ab_stale_stb: busy/rd_vld/done/err=%b required 0000",
                     {bus.busy, bus.rd_vld, bus.done, bus.err});
        end
        // Abort while the write byte is offered: nothing may be accepted.
        prev = bus.wtp_dout;
        pulse_start(1'b1, 2'd1, 8'd0);
        bus.abort   = 1'b1;
        bus.wr_vld  = 1'b1;
        bus.wr_data = 8'hEE;
        #1;
        checks++;
        if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL ab_wr_rdy: got %b required 0", bus.wr_rdy); end
        @(negedge clk);
        bus.abort  = 1'b0;
        bus.wr_vld = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.wtp_dout !== prev) begin
            errors++;
            $display("FAIL ab_fetch: done=%b dout=%h required 1/%h", bus.done, bus.wtp_dout, prev);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int dones;
        pulse_start(1'b0, 2'd1, 8'd5);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dma_wtp_req, bus.busy, bus.rd_vld, bus.wr_rdy} !== 4'b0 || bus.dmawpdev !== 2'd0) begin
            errors++;
            $display("FAIL arst_drop: req/busy/rd_vld/wr_rdy=%b dev=%0d required 0000/0",
                     {bus.dma_wtp_req, bus.busy, bus.rd_vld, bus.wr_rdy}, bus.dmawpdev);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_no_done: done pulses=%0d busy=%b required 0/0", dones, bus.busy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_start_while_busy();
        test_long_read_race();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
